// File: rtl/digital_clock_core_p.sv
// digital_clock_core_p: real-time clock, stopwatch and alarm with button decode and display drive
module digital_clock_core_p #(
  parameter int TICK_DIV  = 50_000_000,
  parameter int FLASH_DIV = 25_000_000,
  parameter int FIELD_W   = 7,
  parameter int HOURS_24  = 1,
  parameter int RING_SECS = 60
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   mode_i,
  input  logic                   set_i,
  input  logic                   op1_i,
  input  logic                   op2_i,
  output logic [1:0]             display_mode_o,
  output logic [2:0]             flash_o,
  output logic [3*FIELD_W-1:0]   out_time_o,
  output logic                   alarm_ring_o
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int FW = $clog2(FLASH_DIV) + 1;
  localparam int RW = $clog2(RING_SECS) + 1;
  localparam logic [6:0] H_LO  = HOURS_24 != 0 ? 7'd0 : 7'd1;
  localparam logic [6:0] H_HI  = HOURS_24 != 0 ? 7'd23 : 7'd12;
  localparam logic [6:0] H_RST = HOURS_24 != 0 ? 7'd0 : 7'd12;

  typedef enum logic [1:0] {RUN, SET_HH, SET_MM, SET_SS} state_e;

  function automatic logic [6:0] step(input logic [6:0] v, input logic [6:0] lo,
                                      input logic [6:0] hi, input logic up);
    return up ? (v == hi ? lo : v + 7'd1) : (v == lo ? hi : v - 7'd1);
  endfunction

  state_e               state_q, state_d;
  logic [3:0]           prev_q, ev;
  logic [1:0]           mode_q, mode_d;
  logic [PW-1:0]        pre_q, pre_d;
  logic [FW-1:0]        fcnt_q, fcnt_d;
  logic [RW-1:0]        rcnt_q, rcnt_d;
  logic                 phase_q, phase_d, tick_q, tick_d;
  logic                 al_en_q, al_en_d, sw_run_q, sw_run_d, ring_q, ring_d;
  logic [6:0]           ch_q, cm_q, cs_q, ch_d, cm_d, cs_d;
  logic [6:0]           ah_q, am_q, as_q, ah_d, am_d, as_d;
  logic [6:0]           wh_q, wm_q, ws_q, wh_d, wm_d, ws_d;
  logic [2:0]           flash_q, flash_d;
  logic [3*FIELD_W-1:0] out_q, out_d;
  logic                 csel, tick, dismiss, op2_ev, flash_wrap, up;

  assign display_mode_o = mode_q;
  assign flash_o        = flash_q;
  assign out_time_o     = out_q;
  assign alarm_ring_o   = ring_q;

  // button decode, mode/set sequencing, timekeeping and alarm next-state
  always_comb begin
    ev         = {mode_i, set_i, op1_i, op2_i} & ~prev_q;
    dismiss    = ring_q & ev[0];
    op2_ev     = ev[0] & ~ring_q;
    up         = ev[1];
    csel       = (state_q != RUN) && (mode_q == 2'd0);
    tick       = !csel && (pre_q == PW'(TICK_DIV - 1));
    flash_wrap = fcnt_q == FW'(FLASH_DIV - 1);
    pre_d      = (csel || tick) ? '0 : pre_q + 1'b1;
    fcnt_d     = flash_wrap ? '0 : fcnt_q + 1'b1;
    phase_d    = phase_q ^ flash_wrap;
    tick_d     = tick;
    state_d    = state_q;
    mode_d     = mode_q;
    al_en_d    = al_en_q;
    sw_run_d   = sw_run_q;
    ring_d     = ring_q;
    rcnt_d     = rcnt_q;
    {ch_d, cm_d, cs_d} = {ch_q, cm_q, cs_q};
    {ah_d, am_d, as_d} = {ah_q, am_q, as_q};
    {wh_d, wm_d, ws_d} = {wh_q, wm_q, ws_q};
    if (state_q == RUN) begin
      if (ev[2] && mode_q != 2'd1) state_d = SET_HH;
      else if (ev[3]) mode_d = mode_q == 2'd2 ? 2'd0 : mode_q + 2'd1;
      if (ev[1] && mode_q == 2'd2) al_en_d = ~al_en_q;
      if (ev[1] && mode_q == 2'd1) sw_run_d = ~sw_run_q;
      if (op2_ev && !ev[1] && mode_q == 2'd1 && !sw_run_q) {wh_d, wm_d, ws_d} = '0;
    end else begin
      if (ev[2]) state_d = state_q == SET_HH ? SET_MM : state_q == SET_MM ? SET_SS : RUN;
      if (ev[1] ^ op2_ev) begin
        if (mode_q == 2'd0) begin
          if (state_q == SET_HH) ch_d = step(ch_q, H_LO, H_HI, up);
          if (state_q == SET_MM) cm_d = step(cm_q, 7'd0, 7'd59, up);
          if (state_q == SET_SS) cs_d = step(cs_q, 7'd0, 7'd59, up);
        end else begin
          if (state_q == SET_HH) ah_d = step(ah_q, H_LO, H_HI, up);
          if (state_q == SET_MM) am_d = step(am_q, 7'd0, 7'd59, up);
          if (state_q == SET_SS) as_d = step(as_q, 7'd0, 7'd59, up);
        end
      end
    end
    if (tick) begin
      cs_d = step(cs_q, 7'd0, 7'd59, 1'b1);
      if (cs_q == 7'd59) cm_d = step(cm_q, 7'd0, 7'd59, 1'b1);
      if (cs_q == 7'd59 && cm_q == 7'd59) ch_d = step(ch_q, H_LO, H_HI, 1'b1);
    end
    if (tick && sw_run_q) begin
      ws_d = step(ws_q, 7'd0, 7'd59, 1'b1);
      if (ws_q == 7'd59) wm_d = step(wm_q, 7'd0, 7'd59, 1'b1);
      if (ws_q == 7'd59 && wm_q == 7'd59) wh_d = step(wh_q, 7'd0, 7'd99, 1'b1);
    end
    if (tick_q && al_en_q && !csel && ch_q == ah_q && cm_q == am_q && cs_q == as_q) begin
      ring_d = 1'b1;
      rcnt_d = '0;
    end
    if (ring_q && tick) begin
      rcnt_d = rcnt_q + 1'b1;
      if (rcnt_q == RW'(RING_SECS - 1)) ring_d = 1'b0;
    end
    if (dismiss || !al_en_d) ring_d = 1'b0;
    flash_d = {state_d == SET_HH, state_d == SET_MM, state_d == SET_SS} & {3{phase_d}};
    out_d   = mode_d == 2'd1 ? {FIELD_W'(wh_d), FIELD_W'(wm_d), FIELD_W'(ws_d)} :
              mode_d == 2'd2 ? {FIELD_W'(ah_d), FIELD_W'(am_d), FIELD_W'(as_d)} :
                               {FIELD_W'(ch_d), FIELD_W'(cm_d), FIELD_W'(cs_d)};
  end

  // state registers; reset discards any edit in progress
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= RUN;
      prev_q   <= '0;
      mode_q   <= 2'd0;
      pre_q    <= '0;
      fcnt_q   <= '0;
      rcnt_q   <= '0;
      phase_q  <= 1'b0;
      tick_q   <= 1'b0;
      al_en_q  <= 1'b0;
      sw_run_q <= 1'b0;
      ring_q   <= 1'b0;
      {ch_q, cm_q, cs_q} <= {H_RST, 7'd0, 7'd0};
      {ah_q, am_q, as_q} <= {H_RST, 7'd0, 7'd0};
      {wh_q, wm_q, ws_q} <= '0;
      flash_q  <= '0;
      out_q    <= {FIELD_W'(H_RST), {(2*FIELD_W){1'b0}}};
    end else begin
      state_q  <= state_d;
      prev_q   <= {mode_i, set_i, op1_i, op2_i};
      mode_q   <= mode_d;
      pre_q    <= pre_d;
      fcnt_q   <= fcnt_d;
      rcnt_q   <= rcnt_d;
      phase_q  <= phase_d;
      tick_q   <= tick_d;
      al_en_q  <= al_en_d;
      sw_run_q <= sw_run_d;
      ring_q   <= ring_d;
      {ch_q, cm_q, cs_q} <= {ch_d, cm_d, cs_d};
      {ah_q, am_q, as_q} <= {ah_d, am_d, as_d};
      {wh_q, wm_q, ws_q} <= {wh_d, wm_d, ws_d};
      flash_q  <= flash_d;
      out_q    <= out_d;
    end
  end
endmodule

// File: doc/digital_clock_core_p.md
# digital_clock_core_p

Parametrised timekeeping core for the digital clock: one block holds the real-time clock, a stopwatch and an alarm, and decodes the four user buttons. It drives the display controller with the current display mode, per-field flash enables and three binary time fields. It generalises the fixed clock core with a configurable tick rate, field width and 12/24-hour format. It adds a stopwatch, an alarm with ring output and a timed ring-out.

## Interface
- TICK_DIV, 50_000_000: clk cycles per 1 s tick (≥2)
- FLASH_DIV, 25_000_000: clk cycles per flash half-period (≥1)
- FIELD_W, 7: width of each time field (≥7)
- HOURS_24, 1: 1 = hours 0..23; 0 = hours 1..12
- RING_SECS, 60: ticks alarm_ring stays high if not dismissed (≥1)
- clk  in  1  system clock; single clock domain
- reset  in  1  asynchronous, active-low; clears all state
- mode  in  1  button level, already synchronised; acts on rising edge
- set  in  1  button level; acts on rising edge
- op1  in  1  button level; acts on rising edge
- op2  in  1  button level; acts on rising edge
- display_mode  out  2  0 CLOCK, 1 STOPWATCH, 2 ALARM (3 never driven)
- flash  out  3  [2] hours, [1] minutes, [0] seconds blank strobe
- out_time  out  3*FIELD_W  {hh, mm, ss} of the displayed mode, binary
- alarm_ring  out  1  alarm active

## Operation
- Edge detect: each button has a previous-value register; event = level & ~prev. Only events act.
- Top state: RUN or SET_HH → SET_MM → SET_SS (SET states only in CLOCK/ALARM modes).
- RUN: mode event cycles display_mode 0→1→2→0. set event in CLOCK or ALARM enters SET_HH; in STOPWATCH it is ignored.
- SET states: op1 increments the selected field with wrap; op2 decrements it with wrap. Ranges: ss/mm 0..59; hh 0..23, or 1..12 if HOURS_24=0. set event advances HH→MM→SS→RUN. mode is ignored.
- CLOCK set edits the live clock. Prescaler and seconds are frozen in SET states and the prescaler is cleared on the return to RUN.
- ALARM set edits alarm registers; the clock keeps running.
- ALARM RUN: op1 event toggles alarm_en.
- STOPWATCH: op1 event toggles run/stop. op2 event clears to 00:00:00 only while stopped; it is ignored while running. Stopwatch advances on the same 1 s tick; hh range 0..99; 99:59:59 wraps to 00:00:00.
- Clock rollover: 23:59:59→00:00:00 (24 h); 12:59:59→01:00:00 (12 h).
- Alarm: when alarm_en=1, not in CLOCK SET, and clock fields equal alarm fields after a clock tick update, alarm_ring is set. It clears after RING_SECS further ticks, on an op2 event, or on alarm_en cleared.
- While alarm_ring=1, an op2 event only dismisses. It has no stopwatch or set effect.
- Simultaneous events, same cycle: set beats mode (mode dropped). op1+op2 in a SET state → no change. op1+op2 in stopwatch → op1 only.
- flash: one-hot of the field being edited, ANDed with flash phase. The phase register toggles every FLASH_DIV cycles and is free-running. flash=0 in RUN.
- out_time: clock fields in mode 0, stopwatch fields in mode 1, alarm fields in mode 2. Upper unused bits of each field are 0.

## Timing
- Reset values (asynchronous, reset low): display_mode=0, flash=0, alarm_ring=0, alarm_en=0, stopwatch stopped at 0.
- Reset values: clock and alarm = 00:00:00 (HOURS_24=1) or 12:00:00 (HOURS_24=0). Prescaler, flash phase and button prev registers = 0.
- Button event: level first sampled high at edge k → state and outputs updated at edge k (visible one cycle after the level rises). Holding a level gives one event.
- Tick: prescaler counts 0..TICK_DIV-1. The time update happens at the edge where the count is TICK_DIV-1, i.e. every TICK_DIV cycles after reset or set exit.
- alarm_ring rises one edge after the matching time appears on the clock registers.
- All outputs are registered; none are combinational from inputs.
- Reset asserted mid-set discards edits and returns to CLOCK RUN.

## Test plan
- Use TICK_DIV=4, FLASH_DIV=2, RING_SECS=3 for all scenarios.
- Reset, run 240 cycles → clock reads 00:01:00, display_mode=0, flash=0.
- Preload 23:59:58 via set/op1/op2, then 2 ticks → 00:00:00. With HOURS_24=0, 12:59:59 plus 1 tick → 01:00:00.
- SET_HH at hh=0, op2 event → hh=23. flash toggles 100/000 every 2 cycles. Seconds are frozen across 20 cycles.
- Stopwatch: op1 start, 12 cycles → 00:00:03. op2 while running → no change. op1 stop, op2 → 00:00:00.
- Alarm 00:00:02 with alarm_en=1, from reset → alarm_ring high the edge after clock shows 00:00:02, low after 3 more ticks. Repeat with op2 dismiss → low next edge, stopwatch unaffected.
- set and mode rising on the same cycle in CLOCK RUN → SET_HH entered, display_mode stays 0.
